// File: rtl/debug_dump_scheduler.sv
// Debug dump scheduler: walks the latch, register and memory sections word by word
// and streams each word MSB-byte-first to a UART transmitter.
module debug_dump_scheduler #(
  parameter int BITS_SIZE  = 32,
  parameter int SIZE_TRAMA = 8,
  parameter int N_LATCH    = 16,
  parameter int N_REGS     = 32,
  parameter int N_MEM      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [BITS_SIZE-1:0]  i_word,
  input  logic                  i_tx_done,
  output logic [1:0]            o_src,
  output logic [4:0]            o_index,
  output logic                  o_tx_start,
  output logic [SIZE_TRAMA-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NBYTES = BITS_SIZE / SIZE_TRAMA;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(NBYTES - 1);
  localparam logic [4:0]       LAST_LATCH = 5'(N_LATCH - 1);
  localparam logic [4:0]       LAST_REGS  = 5'(N_REGS - 1);
  localparam logic [4:0]       LAST_MEM   = 5'(N_MEM - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    FETCH,
    SEND,
    WAIT_TX,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SRC_LATCH = 2'd0,
    SRC_REGS  = 2'd1,
    SRC_MEM   = 2'd2
  } src_e;

  state_e               state_q;
  src_e                 src_q;
  logic [4:0]           index_q;
  logic [BITS_SIZE-1:0] shreg_q;
  logic [CNT_W-1:0]     byte_cnt_q;
  logic                 tx_start_q;
  logic                 busy_q;
  logic                 done_q;

  logic [4:0]           last_index_d;
  logic                 last_byte_d;
  logic                 last_word_d;

  always_comb begin
    last_index_d = LAST_MEM;
    case (src_q)
      SRC_LATCH: last_index_d = LAST_LATCH;
      SRC_REGS:  last_index_d = LAST_REGS;
      default:   last_index_d = LAST_MEM;
    endcase
    last_byte_d = (byte_cnt_q == LAST_BYTE);
    last_word_d = (index_q == last_index_d);
  end

  // Pulse outputs are set on the edge entering SEND/DONE so they are high
  // exactly for the cycle spent in that state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      src_q      <= SRC_LATCH;
      index_q    <= '0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (i_abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_start && !i_abort) begin
              src_q   <= SRC_LATCH;
              index_q <= '0;
              busy_q  <= 1'b1;
              state_q <= SELECT;
            end
          end
          SELECT: state_q <= FETCH;
          FETCH: begin
            shreg_q    <= i_word;
            byte_cnt_q <= '0;
            tx_start_q <= 1'b1;
            state_q    <= SEND;
          end
          SEND: state_q <= WAIT_TX;
          WAIT_TX: begin
            if (i_tx_done) begin
              if (!last_byte_d) begin
                byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                shreg_q    <= shreg_q << SIZE_TRAMA;
                tx_start_q <= 1'b1;
                state_q    <= SEND;
              end else if (!last_word_d) begin
                index_q <= index_q + 5'd1;
                state_q <= SELECT;
              end else if (src_q != SRC_MEM) begin
                src_q   <= (src_q == SRC_LATCH) ? SRC_REGS : SRC_MEM;
                index_q <= '0;
                state_q <= SELECT;
              end else begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_src      = src_q;
  assign o_index    = index_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = shreg_q[BITS_SIZE-1 -: SIZE_TRAMA];
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule
